// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer handshake bundle for sync_fifo_param.
// master drives requests and data; slave (the FIFO) returns data, status and error flags.
interface sync_fifo_param_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);
   logic             wr_en;
   logic             rd_en;
   logic             err_clr;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             empty;
   logic             full;
   logic             almost_empty;
   logic             almost_full;
   logic [AW:0]      count;
   logic             overflow;
   logic             underflow;
   modport master (
      output wr_en, rd_en, err_clr, data_in,
      input  data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
   );
   modport slave (
      input  wr_en, rd_en, err_clr, data_in,
      output data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count and almost-full/empty thresholds.
// Define SYNC_FIFO_ERR_EN to build sticky overflow/underflow flags (cleared by err_clr or rst).
module sync_fifo_param #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input logic               clk,
   input logic               rst,
   sync_fifo_param_if.slave  f
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp, rp;
   logic [AW:0]      cnt;
   logic [WIDTH-1:0] q;
   logic             wa, ra;
   assign f.empty        = cnt == '0;
   assign f.full         = cnt == (AW+1)'(DEPTH);
   assign f.almost_empty = cnt <= (AW+1)'(AE_THRESH);
   assign f.almost_full  = cnt >= (AW+1)'(AF_THRESH);
   assign f.count        = cnt;
   assign f.data_out     = q;
   assign wa = f.wr_en & ~f.full;
   assign ra = f.rd_en & ~f.empty;
   // Storage is never reset; a write coinciding with reset is discarded.
   always_ff @(posedge clk)
      if (wa && !rst) mem[wp] <= f.data_in;
   always_ff @(posedge clk)
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
         q   <= '0;
      end else begin
         if (wa) wp <= wp + 1'b1;
         if (ra) begin
            q  <= mem[rp];
            rp <= rp + 1'b1;
         end
         cnt <= (wa & ~ra) ? cnt + 1'b1 : (ra & ~wa) ? cnt - 1'b1 : cnt;
      end
`ifdef SYNC_FIFO_ERR_EN
   logic ovf, unf;
   // Set takes priority over a same-cycle clear.
   always_ff @(posedge clk)
      if (rst) begin
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         ovf <= (f.wr_en & f.full) | (ovf & ~f.err_clr);
         unf <= (f.rd_en & f.empty) | (unf & ~f.err_clr);
      end
   assign f.overflow  = ovf;
   assign f.underflow = unf;
`else
   assign f.overflow  = 1'b0;
   assign f.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed test-plan sequences plus randomized traffic against a queue model.
module tb_sync_fifo_param;
   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int AF    = DEPTH - 2;
   localparam int AE    = 2;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) f ();
   sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
      .clk(clk), .rst(rst), .f(f)
   );
   int tests = 0;
   int fails = 0;
   int mq[$];
   int m_dout = 0;
   bit m_ovf = 1'b0;
   bit m_unf = 1'b0;
   int seq = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask
   // Drive one cycle, advance the model by the FIFO's acceptance rules, then compare every output.
   task automatic step(input bit r_st, input bit w, input bit r, input int d, input bit clr);
      rst = r_st;
      f.wr_en = w;
      f.rd_en = r;
      f.data_in = d[WIDTH-1:0];
      f.err_clr = clr;
      @(posedge clk);
      if (r_st) begin
         mq.delete();
         m_dout = 0;
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         bit was_full = mq.size() == DEPTH;
         bit was_empty = mq.size() == 0;
`ifdef SYNC_FIFO_ERR_EN
         m_ovf = (w && was_full) || (m_ovf && !clr);
         m_unf = (r && was_empty) || (m_unf && !clr);
`endif
         if (r && !was_empty) m_dout = mq.pop_front();
         if (w && !was_full) mq.push_back(d & ((1 << WIDTH) - 1));
      end
      #1;
      check("count", 32'(f.count), 32'(mq.size()));
      check("empty", 32'(f.empty), 32'(mq.size() == 0));
      check("full", 32'(f.full), 32'(mq.size() == DEPTH));
      check("almost_empty", 32'(f.almost_empty), 32'(mq.size() <= AE));
      check("almost_full", 32'(f.almost_full), 32'(mq.size() >= AF));
      check("data_out", 32'(f.data_out), 32'(m_dout));
      check("overflow", 32'(f.overflow), 32'(m_ovf));
      check("underflow", 32'(f.underflow), 32'(m_unf));
   endtask
   initial begin
      f.wr_en = 1'b0;
      f.rd_en = 1'b0;
      f.data_in = '0;
      f.err_clr = 1'b0;
      step(1, 0, 0, 0, 0);
      check("rst_empty", 32'(f.empty), 32'd1);
      check("rst_af", 32'(f.almost_full), 32'd0);
      for (int i = 1; i <= 16; i++) step(0, 1, 0, i, 0);
      check("fill_full", 32'(f.full), 32'd1);
      check("fill_count", 32'(f.count), 32'd16);
      for (int i = 1; i <= 16; i++) begin
         step(0, 0, 1, 0, 0);
         check("drain_order", 32'(f.data_out), 32'(i));
      end
      check("drain_empty", 32'(f.empty), 32'd1);
      step(0, 0, 1, 0, 0);
      check("rd17_hold", 32'(f.data_out), 32'h10);
`ifdef SYNC_FIFO_ERR_EN
      check("rd17_underflow", 32'(f.underflow), 32'd1);
`endif
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) step(0, 1, 0, 'h20 + i, 0);
      for (int i = 0; i < 40; i++) step(0, 1, 1, 'h28 + i, 0);
      check("wrap_count8", 32'(f.count), 32'd8);
      for (int i = 0; i < 8; i++) step(0, 1, 0, 'h80 + i, 0);
      step(0, 1, 1, 'hEE, 0);
      check("full_both_count", 32'(f.count), 32'd15);
      for (int i = 0; i < 15; i++) begin
         step(0, 0, 1, 0, 0);
         check("dropped_word", 32'(f.data_out == 8'hEE), 32'd0);
      end
      step(0, 0, 0, 0, 1);
      step(0, 1, 1, 'hAA, 0);
      check("empty_both_count", 32'(f.count), 32'd1);
      step(0, 0, 1, 0, 0);
      check("empty_both_read", 32'(f.data_out), 32'hAA);
      for (int i = 0; i < 9; i++) step(0, 1, 0, 'h40 + i, 0);
      step(1, 0, 0, 0, 0);
      check("midrst_count", 32'(f.count), 32'd0);
      check("midrst_dout", 32'(f.data_out), 32'd0);
      step(0, 1, 0, 'h5C, 0);
      step(0, 0, 1, 0, 0);
      check("post_rst_read", 32'(f.data_out), 32'h5C);
      for (int i = 0; i < 16; i++) step(0, 1, 0, i, 0);
      step(0, 1, 0, 'h11, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
`ifdef SYNC_FIFO_ERR_EN
      check("ovf_persist", 32'(f.overflow), 32'd1);
`endif
      step(0, 1, 0, 'h12, 1);
`ifdef SYNC_FIFO_ERR_EN
      check("ovf_set_wins", 32'(f.overflow), 32'd1);
`endif
      step(0, 0, 0, 0, 1);
      check("ovf_cleared", 32'(f.overflow), 32'd0);
      // Random traffic with a write/read bias that drifts so occupancy sweeps the whole range.
      for (int blk = 0; blk < 30; blk++) begin
         int wb = $urandom_range(1, 7);
         int rb = $urandom_range(1, 7);
         for (int i = 0; i < 100; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) < wb, $urandom_range(0, 7) < rb,
                 $urandom_range(0, 255), $urandom_range(0, 19) == 0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, the next generation of the team's 8-bit/16-deep buffer. It adds configurable data width and depth, correct simultaneous read/write accounting, an occupancy count, and programmable almost-full/almost-empty thresholds. Optional sticky overflow/underflow error flags are available. It sits between a producer and a consumer in the same clock domain, for example stream buffering between datapath stages.

## Interface
- `WIDTH`, 8: data word width in bits, ≥1
- `DEPTH`, 16: number of entries; power of two, ≥2
- `AF_THRESH`, DEPTH-2: `almost_full` asserts when count ≥ AF_THRESH; range 1..DEPTH
- `AE_THRESH`, 2: `almost_empty` asserts when count ≤ AE_THRESH; range 0..DEPTH-1
- `AW`, $clog2(DEPTH): pointer width; derived, never overridden

- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `wr_en`  in  1  write request
- `data_in`  in  WIDTH  write data
- `rd_en`  in  1  read request
- `data_out`  out  WIDTH  registered read data
- `empty`  out  1  count == 0
- `full`  out  1  count == DEPTH
- `almost_empty`  out  1  count ≤ AE_THRESH
- `almost_full`  out  1  count ≥ AF_THRESH
- `count`  out  AW+1  current occupancy, 0..DEPTH
- `err_clr`  in  1  clears sticky error flags (ignored when errors are compiled out)
- `overflow`  out  1  sticky: a write was attempted while full
- `underflow`  out  1  sticky: a read was attempted while empty

## Operation
- Storage is a DEPTH×WIDTH register array with write pointer `wp` and read pointer `rp`, each AW bits wide. Pointers wrap naturally from DEPTH-1 to 0.
- Write accept: `wa = wr_en & ~full`. On wa, `mem[wp] <= data_in` and `wp <= wp+1`.
- Read accept: `ra = rd_en & ~empty`. On ra, `data_out <= mem[rp]` and `rp <= rp+1`. Otherwise `data_out` holds its value.
- Count update in a single process:
  - wa & ~ra: count+1
  - ra & ~wa: count-1
  - both or neither: unchanged
- `empty`, `full`, `almost_*` decode combinationally from the registered `count`. There are no other state bits.
- Full with wr_en & rd_en both high: the read is accepted and the write is rejected. Count goes to DEPTH-1, and the data word is dropped.
- Empty with wr_en & rd_en both high: the write is accepted and the read is rejected. Count goes to 1, and `data_out` holds.
- Occupancy 1 with both high: both are accepted. The read returns the stored word and count stays 1.
- Rejected requests change no pointer, no count, and no `data_out`.
- Reset (takes priority over all other inputs):
  - wp, rp, count = 0, so `empty`=1, `full`=0, `almost_empty`=1, and `almost_full`=(AF_THRESH==0 ? 1 : 0), which is 0 for legal values
  - `data_out`=0, `overflow`=`underflow`=0
  - Array contents are not reset.
  - A reset asserted mid-stream discards all contents in that cycle.

## Timing
- Write-to-read latency: a word written at edge N makes `empty` low after edge N. It can be read with rd_en sampled at edge N+1, and appears on `data_out` after edge N+1.
- Read latency: 1 cycle from an accepted rd_en to valid `data_out`. The consumer owns capture timing and there is no valid strobe.
- Flags and `count` reflect all operations accepted up to and including the previous edge.
- Throughput: one write and one read per cycle, sustained.

## Configuration
- `SYNC_FIFO_ERR_EN` defined:
  - `overflow` sets on `wr_en & full`.
  - `underflow` sets on `rd_en & empty`.
  - Both stay set until `err_clr` or `rst`.
  - If set and clear happen in the same cycle, set wins.
- `SYNC_FIFO_ERR_EN` undefined: `overflow` and `underflow` are tied to 0, `err_clr` is unused, and no error flops are built.

## Test plan
- Reset, then write 0x01..0x10 on 16 consecutive cycles (WIDTH=8, DEPTH=16):
  - `full`=1 and `count`=16 after the last write
  - `almost_full` rises once count reaches 14
- From full, 16 consecutive reads: `data_out` = 0x01..0x10 in order, then `empty`=1 and `count`=0. A 17th rd_en leaves `data_out`=0x10; with ERR_EN, `underflow`=1.
- Wrap-around and simultaneous events:
  - Hold count=8 while driving wr_en & rd_en for 40 cycles with incrementing data; `count` stays 8 and output order is preserved across pointer wrap.
  - Full with wr_en & rd_en both high: count goes to 15 and the written word is never read back.
- Empty with wr_en & rd_en both high and data 0xAA: count goes to 1 and `data_out` is unchanged. A read on the next cycle returns 0xAA.
- Assert `rst` with count=9: next cycle `count`=0, `empty`=1, `data_out`=0. A following write/read of 0x5C returns 0x5C, not stale data.
- ERR_EN: wr_en while full sets `overflow`. It persists for 5 idle cycles, and `err_clr` together with another full write keeps it 1. `err_clr` alone drops it to 0.
